// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, payload limit and the
// receive FSM state encoding used by the port checkers.
package router_pkg;

    localparam int LEN_MSB     = 7;
    localparam int LEN_LSB     = 2;
    localparam int ADDR_MSB    = 1;
    localparam int ADDR_LSB    = 0;
    localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W      = ADDR_MSB - ADDR_LSB + 1;
    localparam int MAX_PAYLOAD = 63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/router_out_checker.sv
// Drains one router output port, reassembles header/payload/parity packets,
// forwards payload bytes downstream and keeps good/bad packet counts.
module router_out_checker
    import router_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [7:0]        data_in,
    output logic              read_enb,
    input  logic              sink_ready,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic              byte_sof,
    output logic              byte_eof,
    output logic              pkt_done,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              parity_err,
    output logic              len_err,
    output logic              trunc_err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int OWED_W = $clog2(MAX_PAYLOAD + 2);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    // pkt_done is registered, so trip one count early to land it TIMEOUT
    // cycles after the last issue.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    rx_state_e         state_reg, state_next;
    logic              run_reg, rd_q_reg, done_reg;
    logic              parity_err_reg, len_err_reg, trunc_err_reg;
    logic [ADDR_W-1:0] pkt_addr_reg;
    logic [LEN_W-1:0]  pkt_len_reg;
    logic [7:0]        parity_reg;
    logic [OWED_W-1:0] owed_reg, cap_left_reg;
    logic [TMO_W-1:0]  tmo_reg;

    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_cap, body_cap, last_cap, idle_tick, tmo_hit;
    logic              len_fail, par_fail, done_next, good_next;

    assign hdr_len   = data_in[LEN_MSB:LEN_LSB];
    assign hdr_cap   = (state_reg == HDR) && rd_q_reg;
    assign body_cap  = (state_reg == BODY) && rd_q_reg;
    assign last_cap  = body_cap && (cap_left_reg == OWED_W'(1));
    assign idle_tick = (state_reg == BODY) && (owed_reg != '0) && !vld_out;
    assign tmo_hit   = idle_tick && (tmo_reg == TMO_LAST);
    assign len_fail  = hdr_cap && (hdr_len == '0);
    assign par_fail  = last_cap && (data_in != parity_reg);
    assign done_next = len_fail || last_cap || tmo_hit;
    assign good_next = last_cap && !par_fail;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (read_enb) state_next = HDR;
            HDR:     if (rd_q_reg) state_next = (hdr_len == '0) ? IDLE : BODY;
            BODY:    if (last_cap || tmo_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // run_reg keeps reads off while reset is held and for the first edge after.
    always_comb begin
        read_enb   = 1'b0;
        byte_valid = 1'b0;
        byte_sof   = 1'b0;
        byte_eof   = 1'b0;
        unique case (state_reg)
            IDLE: read_enb = run_reg && vld_out && sink_ready;
            BODY: begin
                read_enb   = run_reg && vld_out && sink_ready && (owed_reg != '0);
                byte_valid = rd_q_reg && (cap_left_reg != OWED_W'(1));
                byte_sof   = byte_valid &&
                             (cap_left_reg == OWED_W'(pkt_len_reg) + OWED_W'(1));
                byte_eof   = byte_valid && (cap_left_reg == OWED_W'(2));
            end
            default: ;
        endcase
        byte_data = byte_valid ? data_in : 8'h00;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_reg        <= 1'b0;
            rd_q_reg       <= 1'b0;
            done_reg       <= 1'b0;
            parity_err_reg <= 1'b0;
            len_err_reg    <= 1'b0;
            trunc_err_reg  <= 1'b0;
            pkt_addr_reg   <= '0;
            pkt_len_reg    <= '0;
            parity_reg     <= '0;
            owed_reg       <= '0;
            cap_left_reg   <= '0;
            tmo_reg        <= '0;
        end else begin
            run_reg  <= 1'b1;
            rd_q_reg <= read_enb;
            done_reg <= done_next;
            if (done_next) begin
                len_err_reg    <= len_fail;
                trunc_err_reg  <= tmo_hit;
                parity_err_reg <= par_fail;
            end
            if (hdr_cap) begin
                pkt_addr_reg <= data_in[ADDR_MSB:ADDR_LSB];
                pkt_len_reg  <= hdr_len;
                parity_reg   <= data_in;
                owed_reg     <= OWED_W'(hdr_len) + OWED_W'(1);
                cap_left_reg <= OWED_W'(hdr_len) + OWED_W'(1);
            end else begin
                if ((state_reg == BODY) && read_enb) begin
                    owed_reg <= owed_reg - OWED_W'(1);
                end
                if (body_cap) begin
                    cap_left_reg <= cap_left_reg - OWED_W'(1);
                    if (!last_cap) begin
                        parity_reg <= parity_reg ^ data_in;
                    end
                end
            end
            if (read_enb || (state_reg != BODY)) begin
                tmo_reg <= '0;
            end else if (idle_tick) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {done_next && !good_next, good_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .resetn(resetn),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign pkt_cnt    = cnt_val[0];
    assign err_cnt    = cnt_val[1];
    assign pkt_done   = done_reg;
    assign pkt_addr   = pkt_addr_reg;
    assign pkt_len    = pkt_len_reg;
    assign parity_err = parity_err_reg;
    assign len_err    = len_err_reg;
    assign trunc_err  = trunc_err_reg;

endmodule

// File: tb/tb_router_out_checker.sv
// Directed bench for router_out_checker: a small router-port FIFO model feeds
// packets and each scenario task checks forwarded bytes, flags and counters.
module tb_router_out_checker;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             resetn, vld_out, read_enb, sink_ready;
    logic [7:0]       data_in, byte_data;
    logic             byte_valid, byte_sof, byte_eof, pkt_done;
    logic [1:0]       pkt_addr;
    logic [5:0]       pkt_len;
    logic             parity_err, len_err, trunc_err;
    logic [CNT_W-1:0] pkt_cnt, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    router_out_checker #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .data_in(data_in),
        .read_enb(read_enb), .sink_ready(sink_ready), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_sof(byte_sof), .byte_eof(byte_eof),
        .pkt_done(pkt_done), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
        .parity_err(parity_err), .len_err(len_err), .trunc_err(trunc_err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Router port model and observation records.
    logic [7:0]       fifo[$];
    bit               gate, sink_mode, rd_pend;
    logic [7:0]       rd_byte;
    int               cyc, last_issue, done_cyc, done_cnt, bad_rd;
    logic [7:0]       obs_data[$];
    bit               obs_sof[$];
    bit               obs_eof[$];
    logic             d_par, d_len, d_trunc;
    logic [1:0]       d_addr;
    logic [5:0]       d_plen;
    logic [CNT_W-1:0] d_pkt, d_err;

    task automatic clear_obs();
        obs_data.delete();
        obs_sof.delete();
        obs_eof.delete();
        done_cnt = 0;
        bad_rd   = 0;
    endtask

    // One clock: drive inputs just after the rising edge, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        data_in    = rd_pend ? rd_byte : 8'hEE;
        vld_out    = gate && (fifo.size() > 0);
        sink_ready = sink_mode ? ((cyc / 3) % 2 == 0) : 1'b1;
        @(negedge clk);
        rd_pend = 1'b0;
        if (read_enb) begin
            if (!vld_out || !sink_ready || fifo.size() == 0) begin
                bad_rd++;
            end else begin
                rd_byte    = fifo.pop_front();
                rd_pend    = 1'b1;
                last_issue = cyc;
            end
        end
        if (byte_valid) begin
            obs_data.push_back(byte_data);
            obs_sof.push_back(byte_sof);
            obs_eof.push_back(byte_eof);
        end
        if (pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
            d_par = parity_err; d_len = len_err; d_trunc = trunc_err;
            d_addr = pkt_addr; d_plen = pkt_len; d_pkt = pkt_cnt; d_err = err_cnt;
            $display("pkt cyc=%0d addr=%0d len=%0d par_err=%0b len_err=%0b trunc_err=%0b pkt_cnt=%0d err_cnt=%0d",
                     cyc, pkt_addr, pkt_len, parity_err, len_err, trunc_err, pkt_cnt, err_cnt);
        end
    endtask

    task automatic run_until_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
    endtask

    task automatic load_pkt(input logic [7:0] hdr, input int npay,
                            input logic [7:0] par, input bit with_par);
        fifo.push_back(hdr);
        for (int i = 0; i < npay; i++) fifo.push_back(8'(i));
        if (with_par) fifo.push_back(par);
    endtask

    task automatic do_reset();
        resetn = 1'b0; gate = 1'b0; sink_mode = 1'b0;
        vld_out = 1'b0; sink_ready = 1'b0; data_in = 8'h00;
        fifo.delete();
        rd_pend = 1'b0;
        clear_obs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        resetn = 1'b0; vld_out = 1'b1; sink_ready = 1'b1; data_in = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({read_enb, byte_valid, byte_sof, byte_eof, pkt_done, parity_err, len_err, trunc_err} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {read_enb, byte_valid, byte_sof, byte_eof, pkt_done, parity_err, len_err, trunc_err});
        end
        n_cmp++;
        if ({byte_data, pkt_addr, pkt_len} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 0000", {byte_data, pkt_addr, pkt_len});
        end
        n_cmp++;
        if ({pkt_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_counters: got pkt=%0d err=%0d expected 0/0", pkt_cnt, err_cnt);
        end
        do_reset();
        repeat (3) step();
        n_cmp++;
        if (read_enb !== 1'b0 || done_cnt != 0) begin
            n_bad++;
            $display("FAIL reset_idle: got read_enb=%b done=%0d expected 0/0", read_enb, done_cnt);
        end
    endtask

    task automatic test_clean8();
        do_reset();
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        gate = 1'b1;
        run_until_done(1, 200);
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL clean8_done: got %0d expected 1", done_cnt); end
        n_cmp++;
        if ({d_len, d_trunc, d_par} !== 3'b000) begin
            n_bad++; $display("FAIL clean8_flags: got %b expected 000", {d_len, d_trunc, d_par});
        end
        n_cmp++;
        if (d_addr !== 2'd2 || d_plen !== 6'd8) begin
            n_bad++; $display("FAIL clean8_hdr: got addr=%0d len=%0d expected 2/8", d_addr, d_plen);
        end
        n_cmp++;
        if (d_pkt !== 16'd1 || d_err !== 16'd0) begin
            n_bad++; $display("FAIL clean8_cnt: got pkt=%0d err=%0d expected 1/0", d_pkt, d_err);
        end
        n_cmp++;
        if (obs_data.size() != 8) begin
            n_bad++; $display("FAIL clean8_beats: got %0d expected 8", obs_data.size());
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_data[i], obs_sof[i], obs_eof[i]} !== {8'(i), i == 0, i == 7}) begin
                n_bad++;
                $display("FAIL clean8_beat%0d: got data=%h sof=%b eof=%b expected %h %b %b",
                         i, obs_data[i], obs_sof[i], obs_eof[i], 8'(i), i == 0, i == 7);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_pkt(8'h3A, 14, 8'h3B, 1'b1);
        load_pkt(8'h3A, 14, 8'h3B, 1'b1);
        gate = 1'b1;
        run_until_done(2, 400);
        n_cmp++;
        if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done: got %0d expected 2", done_cnt); end
        n_cmp++;
        if ({d_len, d_trunc, d_par} !== 3'b000 || d_plen !== 6'd14) begin
            n_bad++; $display("FAIL b2b_flags: got %b len=%0d expected 000 14", {d_len, d_trunc, d_par}, d_plen);
        end
        n_cmp++;
        if (pkt_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL b2b_cnt: got pkt=%0d err=%0d expected 2/0", pkt_cnt, err_cnt);
        end
        n_cmp++;
        if (obs_data.size() != 28) begin
            n_bad++; $display("FAIL b2b_beats: got %0d expected 28", obs_data.size());
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_data[i], obs_sof[i], obs_eof[i]} !== {8'(i % 14), i % 14 == 0, i % 14 == 13}) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got data=%h sof=%b eof=%b expected %h %b %b",
                         i, obs_data[i], obs_sof[i], obs_eof[i], 8'(i % 14), i % 14 == 0, i % 14 == 13);
            end
        end
    endtask

    task automatic test_parity();
        do_reset();
        load_pkt(8'h22, 8, 8'h23, 1'b1);
        gate = 1'b1;
        run_until_done(1, 200);
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b001) begin
            n_bad++; $display("FAIL par_flags: got done=%0d flags=%b expected 1 001", done_cnt, {d_len, d_trunc, d_par});
        end
        n_cmp++;
        if (d_pkt !== 16'd0 || d_err !== 16'd1) begin
            n_bad++; $display("FAIL par_cnt: got pkt=%0d err=%0d expected 0/1", d_pkt, d_err);
        end
        n_cmp++;
        if (parity_err !== 1'b1) begin
            n_bad++; $display("FAIL par_held: got %b expected 1", parity_err);
        end
        n_cmp++;
        if (obs_data.size() != 8) begin
            n_bad++; $display("FAIL par_beats: got %0d expected 8", obs_data.size());
        end
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        run_until_done(2, 200);
        n_cmp++;
        if (done_cnt != 2 || {d_len, d_trunc, d_par} !== 3'b000) begin
            n_bad++; $display("FAIL par_clear: got done=%0d flags=%b expected 2 000", done_cnt, {d_len, d_trunc, d_par});
        end
        n_cmp++;
        if (d_pkt !== 16'd1 || d_err !== 16'd1) begin
            n_bad++; $display("FAIL par_cnt2: got pkt=%0d err=%0d expected 1/1", d_pkt, d_err);
        end
    endtask

    task automatic test_sink_throttle();
        do_reset();
        sink_mode = 1'b1;
        load_pkt(8'h3A, 14, 8'h3B, 1'b1);
        gate = 1'b1;
        run_until_done(1, 400);
        n_cmp++;
        if (bad_rd != 0) begin n_bad++; $display("FAIL sink_read_gate: got %0d stray reads expected 0", bad_rd); end
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b000 || d_pkt !== 16'd1) begin
            n_bad++; $display("FAIL sink_done: got done=%0d flags=%b pkt=%0d expected 1 000 1",
                              done_cnt, {d_len, d_trunc, d_par}, d_pkt);
        end
        n_cmp++;
        if (obs_data.size() != 14) begin
            n_bad++; $display("FAIL sink_beats: got %0d expected 14", obs_data.size());
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== 8'(i)) begin
                n_bad++; $display("FAIL sink_beat%0d: got %h expected %h", i, obs_data[i], 8'(i));
            end
        end
        sink_mode = 1'b0;
    endtask

    task automatic test_resume();
        do_reset();
        load_pkt(8'h3A, 14, 8'h3B, 1'b1);
        gate = 1'b1;
        repeat (8) step();
        gate = 1'b0;
        repeat (20) step();
        n_cmp++;
        if (done_cnt != 0) begin n_bad++; $display("FAIL resume_early_done: got %0d expected 0", done_cnt); end
        gate = 1'b1;
        run_until_done(1, 200);
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b000 || d_pkt !== 16'd1) begin
            n_bad++; $display("FAIL resume_done: got done=%0d flags=%b pkt=%0d expected 1 000 1",
                              done_cnt, {d_len, d_trunc, d_par}, d_pkt);
        end
        n_cmp++;
        if (obs_data.size() != 14 || obs_data[13] !== 8'd13) begin
            n_bad++; $display("FAIL resume_beats: got %0d beats expected 14 ending 0d", obs_data.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_pkt(8'h22, 5, 8'h00, 1'b0);
        gate = 1'b1;
        run_until_done(1, 200);
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b010) begin
            n_bad++; $display("FAIL tmo_flags: got done=%0d flags=%b expected 1 010", done_cnt, {d_len, d_trunc, d_par});
        end
        n_cmp++;
        if (done_cyc - last_issue != TIMEOUT) begin
            n_bad++; $display("FAIL tmo_latency: got %0d expected %0d", done_cyc - last_issue, TIMEOUT);
        end
        n_cmp++;
        if (d_pkt !== 16'd0 || d_err !== 16'd1) begin
            n_bad++; $display("FAIL tmo_cnt: got pkt=%0d err=%0d expected 0/1", d_pkt, d_err);
        end
        n_cmp++;
        if (obs_data.size() != 5 || bad_rd != 0) begin
            n_bad++; $display("FAIL tmo_beats: got %0d beats %0d stray reads expected 5/0", obs_data.size(), bad_rd);
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if ({obs_data[i], obs_sof[i], obs_eof[i]} !== {8'(i), i == 0, 1'b0}) begin
                n_bad++; $display("FAIL tmo_beat%0d: got data=%h sof=%b eof=%b expected %h %b 0",
                                  i, obs_data[i], obs_sof[i], obs_eof[i], 8'(i), i == 0);
            end
        end
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        run_until_done(2, 200);
        n_cmp++;
        if (done_cnt != 2 || {d_len, d_trunc, d_par} !== 3'b000 || d_pkt !== 16'd1 || d_plen !== 6'd8) begin
            n_bad++; $display("FAIL tmo_recover: got done=%0d flags=%b pkt=%0d len=%0d expected 2 000 1 8",
                              done_cnt, {d_len, d_trunc, d_par}, d_pkt, d_plen);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        do_reset();
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        gate = 1'b1;
        run_until_done(1, 200);
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        repeat (6) step();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({read_enb, byte_valid, byte_sof, byte_eof, pkt_done, parity_err, len_err, trunc_err} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_flags: got %b expected 00000000",
                     {read_enb, byte_valid, byte_sof, byte_eof, pkt_done, parity_err, len_err, trunc_err});
        end
        n_cmp++;
        if ({byte_data, pkt_addr, pkt_len} !== 16'h0000 || pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL midrst_state: got data/hdr=%h pkt=%0d err=%0d expected 0000 0 0",
                              {byte_data, pkt_addr, pkt_len}, pkt_cnt, err_cnt);
        end
        repeat (3) begin
            @(negedge clk);
            if (pkt_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin n_bad++; $display("FAIL midrst_no_done: got 1 expected 0"); end
        fifo.delete();
        rd_pend = 1'b0;
        clear_obs();
        resetn = 1'b1;
        load_pkt(8'h22, 8, 8'h22, 1'b1);
        run_until_done(1, 200);
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b000 || d_pkt !== 16'd1 || d_err !== 16'd0) begin
            n_bad++; $display("FAIL midrst_next: got done=%0d flags=%b pkt=%0d err=%0d expected 1 000 1 0",
                              done_cnt, {d_len, d_trunc, d_par}, d_pkt, d_err);
        end
        n_cmp++;
        if (obs_data.size() != 8 || obs_data[0] !== 8'h00 || obs_data[7] !== 8'h07) begin
            n_bad++; $display("FAIL midrst_beats: got %0d beats expected 8 of 00..07", obs_data.size());
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        fifo.push_back(8'h02);
        gate = 1'b1;
        run_until_done(1, 100);
        n_cmp++;
        if (done_cnt != 1 || {d_len, d_trunc, d_par} !== 3'b100) begin
            n_bad++; $display("FAIL len0_flags: got done=%0d flags=%b expected 1 100", done_cnt, {d_len, d_trunc, d_par});
        end
        n_cmp++;
        if (done_cyc - last_issue != 2) begin
            n_bad++; $display("FAIL len0_latency: got %0d expected 2", done_cyc - last_issue);
        end
        n_cmp++;
        if (d_pkt !== 16'd0 || d_err !== 16'd1 || d_addr !== 2'd2 || d_plen !== 6'd0) begin
            n_bad++; $display("FAIL len0_state: got pkt=%0d err=%0d addr=%0d len=%0d expected 0 1 2 0",
                              d_pkt, d_err, d_addr, d_plen);
        end
        n_cmp++;
        if (obs_data.size() != 0) begin
            n_bad++; $display("FAIL len0_beats: got %0d expected 0", obs_data.size());
        end
    endtask

    initial begin
        cyc = 0;
        last_issue = 0;
        done_cyc = 0;
        test_reset();
        test_clean8();
        test_back_to_back();
        test_parity();
        test_sink_throttle();
        test_resume();
        test_timeout();
        test_reset_mid();
        test_len_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
